// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle sequencer for a small RISC-V core: fetch, decode, execute and writeback
// of R/I-type ALU instructions, with halt control and a retired-instruction counter.
module riscv_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic        alu_en,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   input  logic        halt_req,
   output logic        halted,
   output logic        illegal,
   output logic        retire,
   output logic [31:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;
   logic        imem_req_q;
   logic        alu_en_q;
   logic        rf_we_q;
   logic [4:0]  rf_waddr_q;
   logic        illegal_q;
   logic        retire_q;
   logic        halted_q;
   logic        fetch_hs;
   logic        wb_we_d;

   function automatic logic is_legal(input logic [31:0] w);
      logic [6:0] opc;
      logic [6:0] f7;
      logic [2:0] f3;
      opc = w[6:0];
      f7  = w[31:25];
      f3  = w[14:12];
      if (opc == 7'b0010011)
         return 1'b1;
      if (opc == 7'b0110011)
         return (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      return 1'b0;
   endfunction

   // Handshake needs the registered request, so the first post-reset cycle never accepts data
   assign fetch_hs = (state_q == S_FETCH) && imem_req_q && imem_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      retire_cnt_d = retire_cnt_q;
      unique case (state_q)
         S_FETCH: begin
            if (fetch_hs) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (illegal_q) begin
               pc_d    = pc_q + 32'd4;
               state_d = halt_req ? S_HALT : S_FETCH;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: state_d = S_WRITEBACK;
         S_WRITEBACK: begin
            pc_d         = pc_q + 32'd4;
            retire_cnt_d = retire_cnt_q + 32'd1;
            state_d      = halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (!halt_req)
               state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign wb_we_d = (state_d == S_WRITEBACK) && (ir_d[11:7] != 5'd0);

   // Outputs are registered from the next state so each one is glitch-free for its whole state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= 32'd0;
         retire_cnt_q <= 32'd0;
         imem_req_q   <= 1'b0;
         alu_en_q     <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= 5'd0;
         illegal_q    <= 1'b0;
         retire_q     <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         retire_cnt_q <= retire_cnt_d;
         imem_req_q   <= (state_d == S_FETCH);
         alu_en_q     <= (state_d == S_EXECUTE);
         rf_we_q      <= wb_we_d;
         rf_waddr_q   <= wb_we_d ? ir_d[11:7] : 5'd0;
         illegal_q    <= fetch_hs && !is_legal(imem_rdata);
         retire_q     <= (state_d == S_WRITEBACK);
         halted_q     <= (state_d == S_HALT);
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign alu_en     = alu_en_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign illegal    = illegal_q;
   assign retire     = retire_q;
   assign halted     = halted_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Directed bench for riscv_seq_ctrl: legal/illegal decode, fetch wait states, halt,
// counter wrap and reset abort, each checked against hand-computed values.
module tb_riscv_seq_ctrl;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_ADDI5 = 32'h00700293;
   localparam logic [31:0] I_ILL   = 32'h402041B3;
   localparam logic [31:0] I_NOP   = 32'h00100013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] ir;
   logic [31:0] pc;
   logic        alu_en;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        illegal;
   logic        retire;
   logic [31:0] retire_cnt;

   int total = 0;
   int bad   = 0;

   riscv_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .pc         (pc),
      .alu_en     (alu_en),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .halt_req   (halt_req),
      .halted     (halted),
      .illegal    (illegal),
      .retire     (retire),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk32("rst_pc", pc, 32'd0);
      chk32("rst_ir", ir, 32'd0);
      chk32("rst_cnt", retire_cnt, 32'd0);
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_alu", alu_en, 1'b0);
      chk1("rst_we", rf_we, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_illegal", illegal, 1'b0);
      chk1("rst_retire", retire, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk1("post_rst_req", imem_req, 1'b1);
      chk32("post_rst_addr", imem_addr, 32'd0);

      // ADD x3,x1,x2 with zero wait states
      imem_ready = 1'b1;
      imem_rdata = I_ADD;
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk32("add_ir", ir, I_ADD);
      chk1("add_dec_req", imem_req, 1'b0);
      chk1("add_dec_alu", alu_en, 1'b0);
      chk1("add_dec_ill", illegal, 1'b0);
      step();
      chk1("add_exe_alu", alu_en, 1'b1);
      chk1("add_exe_we", rf_we, 1'b0);
      step();
      chk1("add_wb_alu", alu_en, 1'b0);
      chk1("add_wb_we", rf_we, 1'b1);
      chk32("add_wb_waddr", {27'd0, rf_waddr}, 32'd3);
      chk1("add_wb_retire", retire, 1'b1);
      chk32("add_wb_pc", pc, 32'd0);
      step();
      chk32("add_pc", pc, 32'd4);
      chk32("add_cnt", retire_cnt, 32'd1);
      chk1("add_retire_off", retire, 1'b0);
      chk1("add_we_off", rf_we, 1'b0);

      // Three wait cycles before the handshake; rdata is junk while ready is low
      for (int i = 0; i < 4; i++) begin
         chk1("wait_req", imem_req, 1'b1);
         chk32("wait_addr", imem_addr, 32'd4);
         chk32("wait_ir", ir, I_ADD);
         if (i < 3) step();
      end
      imem_ready = 1'b1;
      imem_rdata = I_ADDI5;
      step();
      imem_ready = 1'b0;
      chk32("wait_ir_new", ir, I_ADDI5);
      step();
      step();
      chk1("wait_retire", retire, 1'b1);
      chk1("wait_we", rf_we, 1'b1);
      chk32("wait_waddr", {27'd0, rf_waddr}, 32'd5);
      step();
      chk32("wait_pc", pc, 32'd8);
      chk32("wait_cnt", retire_cnt, 32'd2);

      // Illegal R-type encoding
      imem_ready = 1'b1;
      imem_rdata = I_ILL;
      step();
      imem_ready = 1'b0;
      chk1("ill_pulse", illegal, 1'b1);
      chk1("ill_alu", alu_en, 1'b0);
      chk1("ill_we", rf_we, 1'b0);
      step();
      chk1("ill_pulse_end", illegal, 1'b0);
      chk1("ill_alu2", alu_en, 1'b0);
      chk1("ill_retire", retire, 1'b0);
      chk32("ill_pc", pc, 32'd12);
      chk32("ill_cnt", retire_cnt, 32'd2);
      chk1("ill_req", imem_req, 1'b1);

      // ADDI x0,x0,1 retires without a register write
      imem_ready = 1'b1;
      imem_rdata = I_NOP;
      step();
      imem_ready = 1'b0;
      step();
      step();
      chk1("x0_retire", retire, 1'b1);
      chk1("x0_we", rf_we, 1'b0);
      chk32("x0_waddr", {27'd0, rf_waddr}, 32'd0);
      step();
      chk32("x0_pc", pc, 32'd16);
      chk32("x0_cnt", retire_cnt, 32'd3);

      // Halt requested during EXECUTE
      imem_ready = 1'b1;
      imem_rdata = I_ADD;
      step();
      imem_ready = 1'b0;
      step();
      halt_req = 1'b1;
      step();
      chk1("hlt_wb_retire", retire, 1'b1);
      chk1("hlt_wb_halted", halted, 1'b0);
      step();
      chk1("hlt_halted", halted, 1'b1);
      chk1("hlt_req", imem_req, 1'b0);
      chk32("hlt_pc", pc, 32'd20);
      chk32("hlt_cnt", retire_cnt, 32'd4);
      step();
      chk1("hlt_hold", halted, 1'b1);
      chk32("hlt_hold_pc", pc, 32'd20);
      chk32("hlt_hold_ir", ir, I_ADD);
      halt_req = 1'b0;
      step();
      chk1("hlt_leave", halted, 1'b0);
      chk1("hlt_leave_req", imem_req, 1'b1);
      chk32("hlt_leave_addr", imem_addr, 32'd20);

      // Halt held during a fetch does not interrupt it; taken on illegal DECODE exit
      halt_req = 1'b1;
      step();
      chk1("hf_req", imem_req, 1'b1);
      chk1("hf_halted", halted, 1'b0);
      imem_ready = 1'b1;
      imem_rdata = I_ILL;
      step();
      imem_ready = 1'b0;
      chk1("hf_ill", illegal, 1'b1);
      step();
      chk1("hf_halted2", halted, 1'b1);
      chk32("hf_pc", pc, 32'd24);
      chk32("hf_cnt", retire_cnt, 32'd4);
      halt_req = 1'b0;
      step();
      chk1("hf_resume", imem_req, 1'b1);

      // Counter wrap from all-ones
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      #1;
      chk32("wrap_preset", retire_cnt, 32'hFFFF_FFFF);
      imem_ready = 1'b1;
      imem_rdata = I_ADD;
      step();
      imem_ready = 1'b0;
      step();
      step();
      chk1("wrap_retire", retire, 1'b1);
      step();
      chk32("wrap_cnt", retire_cnt, 32'd0);
      chk32("wrap_pc", pc, 32'd28);

      // Reset asserted mid-fetch
      step();
      rst_n = 1'b0;
      #1;
      chk32("rf_pc", pc, 32'd0);
      chk32("rf_ir", ir, 32'd0);
      chk1("rf_req", imem_req, 1'b0);
      chk1("rf_halted", halted, 1'b0);
      step();
      chk1("rf_retire", retire, 1'b0);
      chk1("rf_we", rf_we, 1'b0);
      rst_n = 1'b1;
      step();
      chk1("rf_req_back", imem_req, 1'b1);

      // Reset asserted mid-instruction aborts writeback and retire
      imem_ready = 1'b1;
      imem_rdata = I_ADD;
      step();
      imem_ready = 1'b0;
      step();
      chk1("ri_alu", alu_en, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("ri_alu_off", alu_en, 1'b0);
      chk32("ri_ir", ir, 32'd0);
      step();
      chk1("ri_retire", retire, 1'b0);
      chk1("ri_we", rf_we, 1'b0);
      chk32("ri_waddr", {27'd0, rf_waddr}, 32'd0);
      rst_n = 1'b1;
      step();
      step();
      chk32("ri_cnt", retire_cnt, 32'd0);
      chk32("ri_pc", pc, 32'd0);
      chk1("ri_req", imem_req, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_seq_ctrl.md
RISCV_SEQ_CTRL -- requirements
Module: riscv_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 32, fetch address, equal to pc.
REQ-006 SHALL have port imem_ready, input, 1, fetch accepted; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port ir, output, 32, latched instruction register driving the execute datapath.
REQ-009 SHALL have port pc, output, 32, current program counter.
REQ-010 SHALL have port alu_en, output, 1, execute-stage enable for the R/I-type datapath.
REQ-011 SHALL have port rf_we, output, 1, GPR write enable.
REQ-012 SHALL have port rf_waddr, output, 5, GPR write address.
REQ-013 SHALL have port halt_req, input, 1, external stop request.
REQ-014 SHALL have port halted, output, 1, high while in HALT.
REQ-015 SHALL have port illegal, output, 1, one-cycle pulse on an undecodable instruction.
REQ-016 SHALL have port retire, output, 1, one-cycle pulse per completed instruction.
REQ-017 SHALL have port retire_cnt, output, 32, count of retired instructions.

Function
REQ-018 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK, HALT, one-hot or encoded.
REQ-019 FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready; on imem_ready, ir<=imem_rdata, next DECODE; otherwise stay in FETCH.
REQ-020 DECODE (1 cycle): legal if opcode 7'b0110011 with {funct7,funct3} in {0000000/000,0100000/000,0000000/001,0000000/010,0000000/011,0000000/100,0000000/101,0100000/101,0000000/110,0000000/111}, or opcode 7'b0010011 (any funct3); legal -> EXECUTE.
REQ-021 DECODE illegal: illegal=1 for that cycle, pc<=pc+4, no rf_we, no retire, retire_cnt unchanged, next FETCH (or HALT per REQ-025).
REQ-022 EXECUTE (1 cycle): alu_en=1, next WRITEBACK; alu_en=0 in all other states.
REQ-023 WRITEBACK (1 cycle): rf_waddr=ir[11:7]; rf_we=1 only if ir[11:7]!=0; retire=1; retire_cnt<=retire_cnt+1 (wraps 32'hFFFF_FFFF->0); pc<=pc+4 (mod 2^32); next FETCH (or HALT).
REQ-024 Throughput: 4 cycles per legal instruction with imem_ready high on the first FETCH cycle; each extra wait cycle adds one.
REQ-025 halt_req SHALL be sampled only on exit from WRITEBACK or illegal DECODE; if high, next state HALT instead of FETCH; never interrupts a fetch or an instruction in flight.
REQ-026 HALT: halted=1, imem_req=0, pc/ir held; leaves to FETCH the cycle after halt_req is sampled low.
REQ-027 ir SHALL change only on a FETCH handshake; rf_waddr SHALL be 0 when rf_we=0.
REQ-028 imem_rdata SHALL be ignored when imem_ready=0 or imem_req=0.

Reset
REQ-029 rst_n low SHALL immediately force: state FETCH, pc=RESET_PC, ir=0, retire_cnt=0, alu_en=0, rf_we=0, rf_waddr=0, illegal=0, retire=0, halted=0; imem_req goes 1 from the first clock after rst_n deasserts.
REQ-030 Reset asserted mid-instruction or mid-fetch SHALL abort it with no rf_we, retire or counter update.

Verification
REQ-031 ADD x3,x1,x2 (32'h002081B3), imem_ready always 1 -> alu_en in cycle 3, rf_we=1/rf_waddr=3 and retire in cycle 4, pc=4, retire_cnt=1.
REQ-032 imem_ready held low 3 cycles -> imem_req/imem_addr stable for 4 cycles, ir unchanged until handshake, instruction retires in cycle 7.
REQ-033 R-type funct7=0100000/funct3=100 (32'h402041B3) -> illegal pulse in DECODE, no alu_en/rf_we/retire, pc+4, retire_cnt unchanged.
REQ-034 ADDI x0,x0,1 (32'h00100013) -> retire=1 with rf_we=0, rf_waddr=0.
REQ-035 halt_req asserted during EXECUTE -> instruction completes, HALT entered, halted=1, imem_req=0; deassert -> FETCH at next pc.
REQ-036 retire_cnt preset path: 2^32 retirements not practical -> force retire_cnt=32'hFFFF_FFFF, retire one -> 0; rst_n pulse mid-FETCH -> pc=RESET_PC, all outputs at reset values.
